param_counter: RTL

PARAM_COUNTER -- requirements
Module: param_counter

---
 rtl/param_counter.sv | 87 ++++++++
 1 files changed

// File: rtl/param_counter.sv
// Up/down counter with a programmable prescaler, a runtime upper bound and
// either wrap-around or saturating behaviour at the ends of the range.
module param_counter #(
    parameter int unsigned WIDTH    = 32,
    parameter int unsigned PSC_W    = 8,
    parameter int unsigned SATURATE = 0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic [WIDTH-1:0] max_value,
    input  logic [PSC_W-1:0] prescale,
    output logic [WIDTH-1:0] count,
    output logic             wrap,
    output logic             at_limit
);

    logic [WIDTH-1:0] count_q, count_d;
    logic [PSC_W-1:0] psc_q, psc_d;
    logic             wrap_q, wrap_d;
    logic             step;

    always_comb begin
        count_d = count_q;
        psc_d   = psc_q;
        wrap_d  = 1'b0;
        step    = 1'b0;

        if (load) begin
            count_d = (load_value > max_value) ? max_value : load_value;
            psc_d   = '0;
        end else if (enable) begin
            if (psc_q >= prescale) begin
                psc_d = '0;
                step  = 1'b1;
            end else begin
                psc_d = psc_q + PSC_W'(1);
            end
        end

        if (step) begin
            if (up) begin
                // >= lets a lowered max_value pull an out-of-range count back in.
                if (count_q >= max_value) begin
                    if (SATURATE != 0) begin
                        count_d = max_value;
                        wrap_d  = (count_q != max_value);
                    end else begin
                        count_d = '0;
                        wrap_d  = 1'b1;
                    end
                end else begin
                    count_d = count_q + WIDTH'(1);
                end
            end else begin
                if (count_q == '0) begin
                    if (SATURATE == 0) begin
                        count_d = max_value;
                        wrap_d  = 1'b1;
                    end
                end else begin
                    count_d = count_q - WIDTH'(1);
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            count_q <= '0;
            psc_q   <= '0;
            wrap_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            psc_q   <= psc_d;
            wrap_q  <= wrap_d;
        end
    end

    assign count    = count_q;
    assign wrap     = wrap_q;
    assign at_limit = up ? (count_q == max_value) : (count_q == '0);

endmodule
